// File: rtl/bp_be_cache_req_arbiter.sv
// Arbitrates the single BE-to-LCE cache service port among num_req_p requesters, one transaction
// outstanding. Define BP_BE_CACHE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module bp_be_cache_req_arbiter #(
  parameter int num_req_p        = 2,
  parameter int req_width_p      = 8,
  parameter int metadata_width_p = 4,
  localparam int lg_num_req_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p*req_width_p-1:0]      req_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  output logic [num_req_p-1:0]                  req_ready_o,
  input  logic [num_req_p*metadata_width_p-1:0] req_metadata_i,
  input  logic [num_req_p-1:0]                  req_metadata_v_i,
  output logic [num_req_p-1:0]                  req_complete_o,
  output logic [req_width_p-1:0]                cache_req_o,
  output logic                                  cache_req_v_o,
  input  logic                                  cache_req_ready_i,
  output logic [metadata_width_p-1:0]           cache_req_metadata_o,
  output logic                                  cache_req_metadata_v_o,
  input  logic                                  cache_req_complete_i,
  output logic                                  busy_o,
  output logic [lg_num_req_lp-1:0]              owner_o,
  output logic                                  error_o
);

  typedef enum logic {e_idle, e_busy} state_e;

  state_e                   state_r, state_n;
  logic [lg_num_req_lp-1:0] rr_ptr_r, rr_ptr_n, owner_r, owner_n, sel;
  logic [lg_num_req_lp:0]   idx_w;
  logic [lg_num_req_lp-1:0] cand;
  logic                     found, error_r, error_n, any_v, accept;

  // Rotating search starting at rr_ptr; wraps modulo num_req_p.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx_w = '0;
    cand  = '0;
    for (int k = 0; k < num_req_p; k++) begin
      idx_w = {1'b0, rr_ptr_r} + (lg_num_req_lp+1)'(k);
      if (idx_w >= (lg_num_req_lp+1)'(num_req_p))
        idx_w = idx_w - (lg_num_req_lp+1)'(num_req_p);
      cand = idx_w[lg_num_req_lp-1:0];
      if (!found && req_v_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Reset gates the request side so nothing is offered while the block is held in reset.
  assign any_v  = (state_r == e_idle) & (|req_v_i) & ~reset_i;
  assign accept = any_v & cache_req_ready_i;

  always_comb begin
    state_n                = state_r;
    rr_ptr_n               = rr_ptr_r;
    owner_n                = owner_r;
    error_n                = error_r;
    req_ready_o            = '0;
    req_complete_o         = '0;
    cache_req_o            = req_i[sel*req_width_p +: req_width_p];
    cache_req_v_o          = 1'b0;
    cache_req_metadata_o   = req_metadata_i[sel*metadata_width_p +: metadata_width_p];
    cache_req_metadata_v_o = 1'b0;
    case (state_r)
      e_idle: begin
        cache_req_v_o          = any_v;
        req_ready_o[sel]       = any_v & cache_req_ready_i;
        cache_req_metadata_v_o = req_metadata_v_i[sel] & accept;
        if (accept) begin
          owner_n = sel;
          state_n = e_busy;
        end
        // A stray completion has no owner; drop it and flag it.
        if (cache_req_complete_i) error_n = 1'b1;
      end
      e_busy: begin
        cache_req_metadata_o   = req_metadata_i[owner_r*metadata_width_p +: metadata_width_p];
        cache_req_metadata_v_o = req_metadata_v_i[owner_r];
        if (cache_req_complete_i) begin
          req_complete_o[owner_r] = 1'b1;
          state_n                 = e_idle;
`ifdef BP_BE_CACHE_ARB_FIXED_PRIO_EN
          rr_ptr_n = '0;
`else
          rr_ptr_n = (owner_r == lg_num_req_lp'(num_req_p-1)) ? '0 : owner_r + 1'b1;
`endif
        end
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      rr_ptr_r <= '0;
      owner_r  <= '0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_n;
      rr_ptr_r <= rr_ptr_n;
      owner_r  <= owner_n;
      error_r  <= error_n;
    end
  end

  assign busy_o  = (state_r == e_busy);
  assign owner_o = owner_r;
  assign error_o = error_r;

endmodule

// File: tb/tb_bp_be_cache_req_arbiter.sv
// Directed bench for bp_be_cache_req_arbiter (2 ports, 8-bit requests, 4-bit metadata).
module tb_bp_be_cache_req_arbiter;
  localparam int NR = 2, RW = 8, MW = 4;

  logic           clk_i = 1'b0, reset_i = 1'b0;
  logic [NR*RW-1:0] req_i = '0;
  logic [NR-1:0]  req_v_i = '0, req_ready_o, req_metadata_v_i = '0, req_complete_o;
  logic [NR*MW-1:0] req_metadata_i = '0;
  logic [RW-1:0]  cache_req_o;
  logic           cache_req_v_o, cache_req_ready_i = 1'b0;
  logic [MW-1:0]  cache_req_metadata_o;
  logic           cache_req_metadata_v_o, cache_req_complete_i = 1'b0;
  logic           busy_o, error_o;
  logic [0:0]     owner_o;

  int n_cmp = 0, n_mis = 0;

  bp_be_cache_req_arbiter #(.num_req_p(NR), .req_width_p(RW), .metadata_width_p(MW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
    .req_metadata_i(req_metadata_i), .req_metadata_v_i(req_metadata_v_i),
    .req_complete_o(req_complete_o), .cache_req_o(cache_req_o), .cache_req_v_o(cache_req_v_o),
    .cache_req_ready_i(cache_req_ready_i), .cache_req_metadata_o(cache_req_metadata_o),
    .cache_req_metadata_v_o(cache_req_metadata_v_o), .cache_req_complete_i(cache_req_complete_i),
    .busy_o(busy_o), .owner_o(owner_o), .error_o(error_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow a #1 settle.
  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
  endtask

  initial begin
    req_i = {8'h5A, 8'hA5};
    req_metadata_i = {4'hC, 4'h3};

    // Reset state, with a request pending to show outputs stay quiet under reset
    reset_i = 1'b1; req_v_i = 2'b01; cache_req_ready_i = 1'b1; #3;
    chk("rst_busy", busy_o, 0); chk("rst_owner", owner_o, 0); chk("rst_err", error_o, 0);
    chk("rst_v", cache_req_v_o, 0); chk("rst_rdy", req_ready_o, 0); chk("rst_cmp", req_complete_o, 0);
    cyc(); reset_i = 1'b0; #1;

    // 1) single port-0 transaction
    chk("t1_v", cache_req_v_o, 1); chk("t1_req", cache_req_o, 8'hA5); chk("t1_rdy", req_ready_o, 2'b01);
    cyc(); req_v_i = 2'b00; #1;
    chk("t1_busy", busy_o, 1); chk("t1_own", owner_o, 0);
    chk("t1_vbusy", cache_req_v_o, 0); chk("t1_rdybusy", req_ready_o, 0);
    cyc(); cyc(); cyc();
    cache_req_complete_i = 1'b1; #1;
    chk("t1_cmp", req_complete_o, 2'b01); chk("t1_busy_cmp", busy_o, 1);
    cyc(); cache_req_complete_i = 1'b0; #1;
    chk("t1_idle", busy_o, 0); chk("t1_err", error_o, 0);

    // 2) both ports valid continuously: round-robin alternates, fixed priority stays on port 0
    do_reset();
    req_v_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int ep;
`ifdef BP_BE_CACHE_ARB_FIXED_PRIO_EN
      ep = 0;
`else
      ep = i % 2;
`endif
      #1;
      chk($sformatf("t2_req%0d", i), cache_req_o, (ep == 0) ? 8'hA5 : 8'h5A);
      chk($sformatf("t2_rdy%0d", i), req_ready_o, 2'b01 << ep);
      cyc();
      chk($sformatf("t2_own%0d", i), owner_o, ep);
      chk($sformatf("t2_rdyb%0d", i), req_ready_o, 0);
      cache_req_complete_i = 1'b1; #1;
      chk($sformatf("t2_cmp%0d", i), req_complete_o, 2'b01 << ep);
      cyc(); cache_req_complete_i = 1'b0;
    end
    req_v_i = 2'b00;

    // 3) metadata passes through from the owner only
    do_reset();
    req_v_i = 2'b10; #1;
    chk("t3_req", cache_req_o, 8'h5A);
    cyc(); req_v_i = 2'b00; #1;
    chk("t3_own", owner_o, 1); chk("t3_mv0", cache_req_metadata_v_o, 0);
    cyc();
    req_metadata_v_i = 2'b01; #1;
    chk("t3_mv_other", cache_req_metadata_v_o, 0);
    cyc();
    req_metadata_v_i = 2'b11; #1;
    chk("t3_mv", cache_req_metadata_v_o, 1); chk("t3_md", cache_req_metadata_o, 4'hC);
    cyc();
    req_metadata_v_i = 2'b00; #1;
    chk("t3_mv_after", cache_req_metadata_v_o, 0);
    cache_req_complete_i = 1'b1; #1;
    chk("t3_cmp", req_complete_o, 2'b10);
    cyc(); cache_req_complete_i = 1'b0;

    // 4) LCE back-pressure holds the request; metadata only flagged on accept
    do_reset();
    req_v_i = 2'b01; req_metadata_v_i = 2'b01; cache_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t4_rdy%0d", i), req_ready_o, 0);
      chk($sformatf("t4_v%0d", i), cache_req_v_o, 1);
      chk($sformatf("t4_mv%0d", i), cache_req_metadata_v_o, 0);
      chk($sformatf("t4_busy%0d", i), busy_o, 0);
      cyc();
    end
    cache_req_ready_i = 1'b1; #1;
    chk("t4_rdy", req_ready_o, 2'b01); chk("t4_mv", cache_req_metadata_v_o, 1);
    chk("t4_md", cache_req_metadata_o, 4'h3);
    cyc(); req_v_i = 2'b00; req_metadata_v_i = 2'b00; #1;
    chk("t4_busy", busy_o, 1);
    cache_req_complete_i = 1'b1;
    cyc(); cache_req_complete_i = 1'b0;

    // 5) stray completion in idle sets sticky error, cleared only by reset
    #1;
    chk("t5_idle", busy_o, 0);
    cache_req_complete_i = 1'b1; #1;
    chk("t5_cmp", req_complete_o, 0);
    cyc(); cache_req_complete_i = 1'b0; #1;
    chk("t5_err", error_o, 1);
    cyc(); cyc(); #1;
    chk("t5_err_hold", error_o, 1);
    reset_i = 1'b1; #1;
    chk("t5_err_rst", error_o, 0);
    cyc(); reset_i = 1'b0;

    // 6) asynchronous reset mid-transaction
    req_v_i = 2'b01;
    cyc(); #1;
    chk("t6_busy", busy_o, 1);
    #2 reset_i = 1'b1; #1;
    chk("t6_busy_rst", busy_o, 0); chk("t6_v_rst", cache_req_v_o, 0);
    chk("t6_rdy_rst", req_ready_o, 0);
    cyc(); reset_i = 1'b0; req_v_i = 2'b00;
    cache_req_complete_i = 1'b1;
    cyc(); cache_req_complete_i = 1'b0; #1;
    chk("t6_late_cmp_err", error_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
